// File: rtl/ternary_sum_pkg.sv
// ---------------------------------------------------------------------------
// ternary_sum_pkg
// Shared types and constants for the ternary_sum_nine streaming sequencer.
//   ts_state_t : sequencer FSM state encoding
//   ts_tag_t   : one entry of the adder-latency tag pipe
//   NLANES     : adder input lanes per group
//   LAT        : adder latency in cycles (lanes stable in t -> result in t+LAT)
//   IDX_W      : width of the lane write index
// ---------------------------------------------------------------------------
package ternary_sum_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ISSUE,
        DRAIN,
        DONE
    } ts_state_t;

    localparam int NLANES = 9;
    localparam int LAT    = 2;
    localparam int IDX_W  = 4;

    typedef struct packed {
        logic v;
        logic last;
    } ts_tag_t;

endpackage

// File: rtl/ternary_sum_nine.sv
// ---------------------------------------------------------------------------
// ternary_sum_nine
// Two-stage pipelined nine-input adder built from 3-input adders.
// Stage 1 registers three partial sums of three lanes each; stage 2 registers
// the sum of the partials. Inputs present in cycle t appear on o_o in t+2.
// Ports:
//   clk_i      clock
//   rst_n_i    synchronous active-low reset (clears pipeline registers)
//   i0_i..i8_i WIDTH-bit operands
//   o_o        WIDTH+4-bit sum (9*(2^WIDTH-1) always fits)
// ---------------------------------------------------------------------------
module ternary_sum_nine #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] i0_i,
    input  logic [WIDTH-1:0] i1_i,
    input  logic [WIDTH-1:0] i2_i,
    input  logic [WIDTH-1:0] i3_i,
    input  logic [WIDTH-1:0] i4_i,
    input  logic [WIDTH-1:0] i5_i,
    input  logic [WIDTH-1:0] i6_i,
    input  logic [WIDTH-1:0] i7_i,
    input  logic [WIDTH-1:0] i8_i,
    output logic [WIDTH+3:0] o_o
);

    logic [WIDTH+1:0] p0_q, p1_q, p2_q;
    logic [WIDTH+3:0] o_q;

    function automatic logic [WIDTH+1:0] sum3(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
        return (WIDTH+2)'(a) + (WIDTH+2)'(b) + (WIDTH+2)'(c);
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            p0_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
            o_q  <= '0;
        end else begin
            p0_q <= sum3(i0_i, i1_i, i2_i);
            p1_q <= sum3(i3_i, i4_i, i5_i);
            p2_q <= sum3(i6_i, i7_i, i8_i);
            o_q  <= (WIDTH+4)'(p0_q) + (WIDTH+4)'(p1_q) + (WIDTH+4)'(p2_q);
        end
    end

    assign o_o = o_q;

endmodule

// File: rtl/ternary_sum_stream_ctrl.sv
// ---------------------------------------------------------------------------
// ternary_sum_stream_ctrl
// Packs an in_valid/in_ready word stream into groups of nine lanes, issues
// each group to a pipelined ternary_sum_nine adder, and accumulates the group
// sums. A vector ends at the word flagged by in_last; its total and word
// count are then offered on out_valid/out_ready.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds data stable while valid && !ready, and the
// DUT holds out_data/out_count stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_data/in_valid/in_last/in_ready   input word stream
//   out_data/out_count/out_valid/out_ready   per-vector result
//   busy                  FSM not idle or an adder result still in flight
//   out_ovf               sticky accumulator carry-out (SUM_OVERFLOW_EN only)
//
// Configuration macro: SUM_OVERFLOW_EN adds out_ovf and its carry logic;
// without it the accumulator wraps silently.
// ---------------------------------------------------------------------------
module ternary_sum_stream_ctrl
    import ternary_sum_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = WIDTH + 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef SUM_OVERFLOW_EN
    ,
    output logic             out_ovf
`endif
);

    ts_state_t         state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              grp_last_q;
    logic [WIDTH-1:0]  lane_q [NLANES];
    ts_tag_t           tag_q [LAT];
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  count_q;
    logic              out_valid_q;

    logic              accept;
    logic              tag_busy;
    ts_tag_t           tag_exit;
    logic [WIDTH+3:0]  add_o;
    logic [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]  count_d;

    // Words are only taken while collecting; reset forces ready low.
    assign in_ready = rst_n && ((state_q == IDLE) || (state_q == FILL));
    assign accept   = in_valid && in_ready;

    // The oldest tag lines up with the adder output of its group.
    assign tag_exit = tag_q[LAT-1];

    always_comb begin
        tag_busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            tag_busy = tag_busy | tag_q[i].v;
        end
    end

    // Word count saturates instead of wrapping.
    assign count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

`ifdef SUM_OVERFLOW_EN
    logic [ACC_W:0] acc_sum;
    logic           ovf_q;
    assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(add_o);
    assign acc_d   = acc_sum[ACC_W-1:0];
    assign out_ovf = ovf_q;
`else
    assign acc_d   = acc_q + ACC_W'(add_o);
`endif

    ternary_sum_nine #(
        .WIDTH (WIDTH)
    ) u_add (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .i0_i    (lane_q[0]),
        .i1_i    (lane_q[1]),
        .i2_i    (lane_q[2]),
        .i3_i    (lane_q[3]),
        .i4_i    (lane_q[4]),
        .i5_i    (lane_q[5]),
        .i6_i    (lane_q[6]),
        .i7_i    (lane_q[7]),
        .i8_i    (lane_q[8]),
        .o_o     (add_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            grp_last_q  <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NLANES; i++) begin
                lane_q[i] <= '0;
            end
            // Clearing the tags drops any adder result still in flight.
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
`ifdef SUM_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            // Tag pipe: a tag enters on the ISSUE cycle and exits LAT later.
            if (state_q == ISSUE) begin
                tag_q[0] <= '{v: 1'b1, last: grp_last_q};
            end else begin
                tag_q[0] <= '0;
            end
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end

            // Background accumulation of completed groups.
            if (tag_exit.v) begin
                acc_q <= acc_d;
`ifdef SUM_OVERFLOW_EN
                ovf_q <= ovf_q | acc_sum[ACC_W];
`endif
            end

            case (state_q)
                IDLE: begin
                    acc_q       <= '0;
                    count_q     <= '0;
                    out_valid_q <= 1'b0;
`ifdef SUM_OVERFLOW_EN
                    ovf_q       <= 1'b0;
`endif
                    if (accept) begin
                        lane_q[0]  <= in_data;
                        idx_q      <= IDX_W'(1);
                        count_q    <= CNT_W'(1);
                        grp_last_q <= in_last;
                        state_q    <= in_last ? ISSUE : FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        lane_q[idx_q] <= in_data;
                        idx_q         <= idx_q + IDX_W'(1);
                        count_q       <= count_d;
                        if ((idx_q == IDX_W'(NLANES - 1)) || in_last) begin
                            grp_last_q <= in_last;
                            state_q    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // Lanes were sampled by the adder this cycle; zero them so
                    // a short next group is zero-padded.
                    for (int i = 0; i < NLANES; i++) begin
                        lane_q[i] <= '0;
                    end
                    idx_q   <= '0;
                    state_q <= grp_last_q ? DRAIN : FILL;
                end
                DRAIN: begin
                    if (tag_exit.v && tag_exit.last) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
`ifdef SUM_OVERFLOW_EN
                        ovf_q       <= 1'b0;
`endif
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_data  = acc_q;
    assign out_count = count_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE) || tag_busy;

endmodule

// File: tb/tb_ternary_sum_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ternary_sum_stream_ctrl
// Directed vectors plus a random soak for ternary_sum_stream_ctrl. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected results are queued by the stimulus and compared by
// an independent monitor whenever out_valid is high.
// ---------------------------------------------------------------------------
module tb_ternary_sum_stream_ctrl;

    localparam int WIDTH = 16;
`ifdef SUM_OVERFLOW_EN
    localparam int ACC_W = 20;
`else
    localparam int ACC_W = WIDTH + 12;
`endif
    localparam int CNT_W = 16;
    localparam int EW    = 1 + CNT_W + ACC_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
`ifdef SUM_OVERFLOW_EN
    logic             out_ovf;
`endif

    ternary_sum_stream_ctrl #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef SUM_OVERFLOW_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters and check helper ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];

    task automatic push_lit(input logic [ACC_W-1:0] d, input int n, input logic ovf);
        exp_q.push_back({ovf, CNT_W'(n), d});
    endtask

    task automatic push_model(input logic [63:0] total, input int n);
        logic [ACC_W-1:0] d;
        logic             ovf;
        int               nc;
        d   = total[ACC_W-1:0];
        ovf = (total >= (64'd1 << ACC_W));
        nc  = (n > 65535) ? 65535 : n;
        exp_q.push_back({ovf, CNT_W'(nc), d});
    endtask

    // Monitor: every cycle a result is offered it must match the queue head,
    // which also covers stability while out_ready is low.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: data=%0d count=%0d", out_data, out_count);
            end else begin
                logic [EW-1:0] e;
                e = exp_q[0];
                chk("out_data", 64'(out_data), 64'(e[ACC_W-1:0]));
                chk("out_count", 64'(out_count), 64'(e[ACC_W +: CNT_W]));
`ifdef SUM_OVERFLOW_EN
                chk("out_ovf", 64'(out_ovf), 64'(e[EW-1]));
`endif
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- out_ready driver ----------------
    // 0: always ready, 1: never ready, 2: random
    int ready_mode = 0;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // ---------------- input driver tasks ----------------
    int stall_cnt = 0;
    int last_acc  = 0;

    // Present one word and hold it until accepted; returns 1 time unit after
    // the accepting edge. last_acc records the accepting cycle.
    task automatic send_word(input logic [WIDTH-1:0] d, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stall_cnt++;
            guard++;
            if (guard > 200) begin
                flag_timeout("send_word");
                break;
            end
            @(posedge clk);
            #1;
        end
        last_acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for the first falling edge with out_valid high; returns its cycle.
    task automatic wait_valid(input string name, output int vcyc);
        int guard;
        guard = 0;
        vcyc  = -1;
        while (guard < 100) begin
            @(negedge clk);
            if (out_valid) begin
                vcyc = cyc;
                break;
            end
            guard++;
        end
        if (vcyc < 0) flag_timeout(name);
    endtask

    // Wait until every queued result has been consumed, then realign.
    task automatic wait_empty(input string name, input int budget);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) flag_timeout(name);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main stimulus ----------------
    int vcyc;
    int zeros;
    logic [WIDTH-1:0] words [40];

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset values while reset is held.
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef SUM_OVERFLOW_EN
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // 1: nine ones, latency from last word to out_valid.
        push_lit(9, 9, 1'b0);
        for (int i = 0; i < 9; i++) send_word(16'd1, i == 8);
        @(negedge clk);
        chk("t1_issue_in_ready", 64'(in_ready), 64'd0);
        chk("t1_issue_cycle", 64'(cyc - last_acc), 64'd1);
        @(posedge clk);
        #1;
        wait_valid("t1_out_valid", vcyc);
        chk("t1_latency", 64'(vcyc - last_acc), 64'd4);
        wait_empty("t1_drain", 50);

        // 2: single full-scale word; in_ready low for exactly four cycles.
        push_lit(65535, 1, 1'b0);
        send_word(16'hFFFF, 1'b1);
        zeros = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) break;
            zeros++;
        end
        chk("t2_ready_low_cycles", 64'(zeros), 64'd4);
        wait_empty("t2_drain", 50);

        // 3: twenty full-scale words, continuous valid; two mid-vector stalls.
        push_lit(1310700, 20, 1'b0);
        stall_cnt = 0;
        for (int i = 0; i < 20; i++) send_word(16'hFFFF, i == 19);
        chk("t3_issue_stalls", 64'(stall_cnt), 64'd2);
        wait_empty("t3_drain", 50);

        // 4: {3,4,5} held by out_ready=0 for ten cycles.
        ready_mode = 1;
        push_lit(12, 3, 1'b0);
        send_word(16'd3, 1'b0);
        send_word(16'd4, 1'b0);
        send_word(16'd5, 1'b1);
        wait_valid("t4_out_valid", vcyc);
        for (int k = 0; k < 10; k++) begin
            if (k != 0) @(negedge clk);
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_in_ready", 64'(in_ready), 64'd0);
        end
        chk("t4_hold_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        ready_mode = 0;
        @(negedge clk);
        chk("t4_pop_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("t4_idle_valid", 64'(out_valid), 64'd0);
        chk("t4_idle_in_ready", 64'(in_ready), 64'd1);
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // 5: reset mid-FILL with a group in flight, then a clean vector.
        for (int i = 0; i < 10; i++) send_word(16'd7, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_out_data", 64'(out_data), 64'd0);
        chk("t5_out_count", 64'(out_count), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        push_lit(15, 3, 1'b0);
        for (int i = 0; i < 3; i++) send_word(16'd5, i == 2);
        wait_empty("t5_drain", 50);

`ifdef SUM_OVERFLOW_EN
        // 6: seventeen full-scale words wrap a 20-bit accumulator.
        push_lit(65519, 17, 1'b1);
        for (int i = 0; i < 17; i++) send_word(16'hFFFF, i == 16);
        wait_empty("t6_drain", 50);
        push_lit(1, 1, 1'b0);
        send_word(16'd1, 1'b1);
        wait_empty("t6b_drain", 50);
`endif

        // Random soak: reference sum accumulated in 64 bits.
        ready_mode = 2;
        for (int v = 0; v < 1000; v++) begin
            int          len;
            logic [63:0] total;
            len   = $urandom_range(1, 40);
            total = '0;
            for (int w = 0; w < len; w++) begin
                words[w] = WIDTH'($urandom_range(0, 65535));
                total    = total + 64'(words[w]);
            end
            push_model(total, len);
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
                send_word(words[w], w == len - 1);
            end
        end
        wait_empty("rand_drain", 200);
        ready_mode = 0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
